// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM state encoding and the forwarding-select helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_STALL     = 2'd1,
        HZ_IRQ_DRAIN = 2'd2
    } hz_state_e;

    // MEM wins over WB because it holds the younger result; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       rw_mem,
        input logic [4:0] wa_mem,
        input logic       rw_wb,
        input logic [4:0] wa_wb,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rw_mem && (wa_mem != 5'd0) && (wa_mem == src)) begin
            sel = FWD_MEM;
        end else if (rw_wb && (wa_wb != 5'd0) && (wa_wb == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-stage fields seen by the hazard controller and the
// stall/flush/forward strobes it returns; dbg_state exposes the FSM.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_ctrl_pkg::*;

    logic [4:0]       RsAddr_id;
    logic [4:0]       RtAddr_id;
    logic             UsesRs_id;
    logic             UsesRt_id;
    logic             BrJmp_id;
    logic             Kernel_id;
    logic [4:0]       RsAddr_ex;
    logic [4:0]       RtAddr_ex;
    logic [4:0]       WrAddr_ex;
    logic             RegWrite_ex;
    logic             MemRead_ex;
    logic             Branch_ex;
    logic             BrTaken_ex;
    logic [4:0]       WrAddr_mem;
    logic             RegWrite_mem;
    logic [4:0]       WrAddr_wb;
    logic             RegWrite_wb;
    logic             IRQ;

    logic             PC_Hold;
    logic             IFID_Hold;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             IRQ_Take;
    logic [1:0]       ForwardA_ex;
    logic [1:0]       ForwardB_ex;
    logic [CNT_W-1:0] StallCount;
    hz_state_e        dbg_state;

    // Pipeline side: supplies stage fields, consumes strobes.
    modport master (
        output RsAddr_id, RtAddr_id, UsesRs_id, UsesRt_id, BrJmp_id, Kernel_id,
        output RsAddr_ex, RtAddr_ex, WrAddr_ex, RegWrite_ex, MemRead_ex,
        output Branch_ex, BrTaken_ex, WrAddr_mem, RegWrite_mem,
        output WrAddr_wb, RegWrite_wb, IRQ,
        input  PC_Hold, IFID_Hold, IFID_Flush, IDEX_Bubble, IRQ_Take,
        input  ForwardA_ex, ForwardB_ex, StallCount, dbg_state
    );

    // Controller side.
    modport slave (
        input  RsAddr_id, RtAddr_id, UsesRs_id, UsesRt_id, BrJmp_id, Kernel_id,
        input  RsAddr_ex, RtAddr_ex, WrAddr_ex, RegWrite_ex, MemRead_ex,
        input  Branch_ex, BrTaken_ex, WrAddr_mem, RegWrite_mem,
        input  WrAddr_wb, RegWrite_wb, IRQ,
        output PC_Hold, IFID_Hold, IFID_Flush, IDEX_Bubble, IRQ_Take,
        output ForwardA_ex, ForwardB_ex, StallCount, dbg_state
    );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module hazard_ctrl_forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr_ex_i,
    input  logic [4:0] rt_addr_ex_i,
    input  logic [4:0] wr_addr_mem_i,
    input  logic       reg_write_mem_i,
    input  logic [4:0] wr_addr_wb_i,
    input  logic       reg_write_wb_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    assign fwd_a_o = fwd_sel(reg_write_mem_i, wr_addr_mem_i,
                             reg_write_wb_i, wr_addr_wb_i, rs_addr_ex_i);
    assign fwd_b_o = fwd_sel(reg_write_mem_i, wr_addr_mem_i,
                             reg_write_wb_i, wr_addr_wb_i, rt_addr_ex_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// interrupt entry, plus EX forwarding selects and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    hz_state_e        state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic luh;
    logic brf;
    logic irq_ok;
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic irq_take;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign luh = hz.MemRead_ex & hz.RegWrite_ex & (hz.WrAddr_ex != 5'd0) &
                 ((hz.UsesRs_id & (hz.RsAddr_id == hz.WrAddr_ex)) |
                  (hz.UsesRt_id & (hz.RtAddr_id == hz.WrAddr_ex)));
    assign brf = hz.Branch_ex & hz.BrTaken_ex;

    // An IRQ may not split a branch from its delay/target fetch, nor nest in kernel code.
    assign irq_ok = irq_pend_q & ~hz.Kernel_id & ~hz.BrJmp_id;

    hazard_ctrl_forward_unit u_fwd (
        .rs_addr_ex_i    (hz.RsAddr_ex),
        .rt_addr_ex_i    (hz.RtAddr_ex),
        .wr_addr_mem_i   (hz.WrAddr_mem),
        .reg_write_mem_i (hz.RegWrite_mem),
        .wr_addr_wb_i    (hz.WrAddr_wb),
        .reg_write_wb_i  (hz.RegWrite_wb),
        .fwd_a_o         (fwd_a_raw),
        .fwd_b_o         (fwd_b_raw)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        irq_take    = 1'b0;

        case (state_q)
            HZ_RUN: begin
                if (brf) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (luh) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = 3'(LOAD_STALL_CYC - 1);
                    if (LOAD_STALL_CYC > 1) begin
                        state_d = HZ_STALL;
                    end
                end else if (irq_ok) begin
                    irq_take    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = HZ_IRQ_DRAIN;
                end
            end
            HZ_STALL: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = HZ_RUN;
                end
            end
            HZ_IRQ_DRAIN: begin
                // Kill the sequential fetch that left IF before the vector was loaded.
                ifid_flush = 1'b1;
                state_d    = HZ_RUN;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase

        if (reset) begin
            pc_hold     = 1'b0;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            irq_take    = 1'b0;
        end
    end

    always_comb begin
        irq_pend_d = irq_take ? 1'b0 : (irq_pend_q | hz.IRQ);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HZ_RUN;
            cnt_q       <= 3'd0;
            irq_pend_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            irq_pend_q  <= irq_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.PC_Hold     = pc_hold;
    assign hz.IFID_Hold   = ifid_hold;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.IDEX_Bubble = idex_bubble;
    assign hz.IRQ_Take    = irq_take;
    assign hz.ForwardA_ex = reset ? FWD_RF : fwd_a_raw;
    assign hz.ForwardB_ex = reset ? FWD_RF : fwd_b_raw;
    assign hz.StallCount  = stall_cnt_q;
    assign hz.dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (1, 3 and 4 stall cycles)
// share one stimulus stream; expected strobes are queued per instance.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct packed {
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       us_rs;
        logic       us_rt;
        logic       brjmp;
        logic       kern;
        logic [4:0] rs_ex;
        logic [4:0] rt_ex;
        logic [4:0] wa_ex;
        logic       rw_ex;
        logic       mr_ex;
        logic       br_ex;
        logic       tk_ex;
        logic [4:0] wa_mem;
        logic       rw_mem;
        logic [4:0] wa_wb;
        logic       rw_wb;
        logic       irq;
    } stim_t;

    // Expected vector: {PC_Hold, IFID_Hold, IFID_Flush, IDEX_Bubble, IRQ_Take, FwdA, FwdB}
    localparam logic [8:0] NONE = 9'b0_0000_0000;
    localparam logic [8:0] HOLD = 9'b1_1010_0000;
    localparam logic [8:0] FLB  = 9'b0_0110_0000;
    localparam logic [8:0] TAKE = 9'b0_0111_0000;
    localparam logic [8:0] DRN  = 9'b0_0100_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [8:0] exp_q1[$];
    logic [8:0] exp_q3[$];
    logic [8:0] exp_q4[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) if1 ();
    hazard_ctrl_if #(.CNT_W(2))  if3 ();
    hazard_ctrl_if #(.CNT_W(16)) if4 ();

    hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .hz(if1));
    hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(2))  u3 (.clk(clk), .reset(reset), .hz(if3));
    hazard_ctrl #(.LOAD_STALL_CYC(4), .CNT_W(16)) u4 (.clk(clk), .reset(reset), .hz(if4));

    wire [8:0] o1 = {if1.PC_Hold, if1.IFID_Hold, if1.IFID_Flush, if1.IDEX_Bubble,
                     if1.IRQ_Take, if1.ForwardA_ex, if1.ForwardB_ex};
    wire [8:0] o3 = {if3.PC_Hold, if3.IFID_Hold, if3.IFID_Flush, if3.IDEX_Bubble,
                     if3.IRQ_Take, if3.ForwardA_ex, if3.ForwardB_ex};
    wire [8:0] o4 = {if4.PC_Hold, if4.IFID_Hold, if4.IFID_Flush, if4.IDEX_Bubble,
                     if4.IRQ_Take, if4.ForwardA_ex, if4.ForwardB_ex};

    task automatic drive(input stim_t s);
        if1.RsAddr_id = s.rs_id;     if3.RsAddr_id = s.rs_id;     if4.RsAddr_id = s.rs_id;
        if1.RtAddr_id = s.rt_id;     if3.RtAddr_id = s.rt_id;     if4.RtAddr_id = s.rt_id;
        if1.UsesRs_id = s.us_rs;     if3.UsesRs_id = s.us_rs;     if4.UsesRs_id = s.us_rs;
        if1.UsesRt_id = s.us_rt;     if3.UsesRt_id = s.us_rt;     if4.UsesRt_id = s.us_rt;
        if1.BrJmp_id = s.brjmp;      if3.BrJmp_id = s.brjmp;      if4.BrJmp_id = s.brjmp;
        if1.Kernel_id = s.kern;      if3.Kernel_id = s.kern;      if4.Kernel_id = s.kern;
        if1.RsAddr_ex = s.rs_ex;     if3.RsAddr_ex = s.rs_ex;     if4.RsAddr_ex = s.rs_ex;
        if1.RtAddr_ex = s.rt_ex;     if3.RtAddr_ex = s.rt_ex;     if4.RtAddr_ex = s.rt_ex;
        if1.WrAddr_ex = s.wa_ex;     if3.WrAddr_ex = s.wa_ex;     if4.WrAddr_ex = s.wa_ex;
        if1.RegWrite_ex = s.rw_ex;   if3.RegWrite_ex = s.rw_ex;   if4.RegWrite_ex = s.rw_ex;
        if1.MemRead_ex = s.mr_ex;    if3.MemRead_ex = s.mr_ex;    if4.MemRead_ex = s.mr_ex;
        if1.Branch_ex = s.br_ex;     if3.Branch_ex = s.br_ex;     if4.Branch_ex = s.br_ex;
        if1.BrTaken_ex = s.tk_ex;    if3.BrTaken_ex = s.tk_ex;    if4.BrTaken_ex = s.tk_ex;
        if1.WrAddr_mem = s.wa_mem;   if3.WrAddr_mem = s.wa_mem;   if4.WrAddr_mem = s.wa_mem;
        if1.RegWrite_mem = s.rw_mem; if3.RegWrite_mem = s.rw_mem; if4.RegWrite_mem = s.rw_mem;
        if1.WrAddr_wb = s.wa_wb;     if3.WrAddr_wb = s.wa_wb;     if4.WrAddr_wb = s.wa_wb;
        if1.RegWrite_wb = s.rw_wb;   if3.RegWrite_wb = s.rw_wb;   if4.RegWrite_wb = s.rw_wb;
        if1.IRQ = s.irq;             if3.IRQ = s.irq;             if4.IRQ = s.irq;
    endtask

    task automatic compare_one(input string t, input string inst, input logic [8:0] obs,
                               input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %b expected %b", t, inst, obs, exp);
        end
    endtask

    task automatic scoreboard_pop;
        string t;
        t = tag_q.pop_front();
        compare_one(t, "u1", o1, exp_q1.pop_front());
        compare_one(t, "u3", o3, exp_q3.pop_front());
        compare_one(t, "u4", o4, exp_q4.pop_front());
    endtask

    // One clock: drive after the edge, queue expectations, check on the falling edge.
    task automatic step(input stim_t s, input logic rst, input logic [8:0] e1,
                        input logic [8:0] e3, input logic [8:0] e4, input string tag);
        @(posedge clk);
        #1;
        reset = rst;
        drive(s);
        exp_q1.push_back(e1);
        exp_q3.push_back(e3);
        exp_q4.push_back(e4);
        tag_q.push_back(tag);
        @(negedge clk);
        scoreboard_pop();
    endtask

    task automatic check_cnt(input logic [31:0] c1, input logic [31:0] c3,
                             input logic [31:0] c4, input string tag);
        logic [31:0] a1, a3, a4;
        a1 = 32'(if1.StallCount);
        a3 = 32'(if3.StallCount);
        a4 = 32'(if4.StallCount);
        n_vec++;
        assert (a1 === c1) else begin
            n_err++; $error("FAIL %s/u1: observed %0d expected %0d", tag, a1, c1);
        end
        n_vec++;
        assert (a3 === c3) else begin
            n_err++; $error("FAIL %s/u3: observed %0d expected %0d", tag, a3, c3);
        end
        n_vec++;
        assert (a4 === c4) else begin
            n_err++; $error("FAIL %s/u4: observed %0d expected %0d", tag, a4, c4);
        end
    endtask

    task automatic check_state(input hz_state_e exp, input string tag);
        n_vec++;
        assert (if4.dbg_state === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, if4.dbg_state, exp);
        end
    endtask

    // Load-use hazard followed by idle cycles until every instance is back in RUN.
    task automatic luh_burst(input stim_t s, input string tag, input logic [31:0] m1,
                             input logic [31:0] m3, input logic [31:0] m4,
                             input logic [31:0] f1, input logic [31:0] f3,
                             input logic [31:0] f4);
        stim_t idle;
        idle = '0;
        step(s,    1'b0, HOLD, HOLD, HOLD, {tag, "_c0"});
        step(idle, 1'b0, NONE, HOLD, HOLD, {tag, "_c1"});
        check_cnt(m1, m3, m4, {tag, "_cnt_first"});
        step(idle, 1'b0, NONE, HOLD, HOLD, {tag, "_c2"});
        step(idle, 1'b0, NONE, NONE, HOLD, {tag, "_c3"});
        step(idle, 1'b0, NONE, NONE, NONE, {tag, "_c4"});
        check_cnt(f1, f3, f4, {tag, "_cnt_final"});
    endtask

    function automatic stim_t fwd_stim(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic rwm, input logic [4:0] wam,
                                       input logic rww, input logic [4:0] waw);
        stim_t s;
        s = '0;
        s.rs_ex = rs; s.rt_ex = rt;
        s.rw_mem = rwm; s.wa_mem = wam;
        s.rw_wb = rww; s.wa_wb = waw;
        return s;
    endfunction

    initial begin
        stim_t idle, s_luh, s_rst, s;

        idle = '0;
        s_luh = '0;
        s_luh.mr_ex = 1'b1; s_luh.rw_ex = 1'b1; s_luh.wa_ex = 5'd8;
        s_luh.rs_id = 5'd8; s_luh.us_rs = 1'b1; s_luh.rt_id = 5'd1; s_luh.us_rt = 1'b1;
        drive(idle);

        // Reset: hazards, branch, forwarding matches and IRQ all present, outputs quiet.
        s_rst = s_luh;
        s_rst.br_ex = 1'b1; s_rst.tk_ex = 1'b1; s_rst.irq = 1'b1;
        s_rst.rs_ex = 5'd5; s_rst.rt_ex = 5'd6;
        s_rst.rw_mem = 1'b1; s_rst.wa_mem = 5'd5; s_rst.rw_wb = 1'b1; s_rst.wa_wb = 5'd6;
        step(s_rst, 1'b1, NONE, NONE, NONE, "reset_a");
        step(s_rst, 1'b1, NONE, NONE, NONE, "reset_b");
        check_cnt(0, 0, 0, "reset_cnt");
        step(idle, 1'b0, NONE, NONE, NONE, "post_reset_idle");
        step(idle, 1'b0, NONE, NONE, NONE, "irq_in_reset_dropped");

        // lw $8 then add $9,$8,$1; u3 counter saturates at 3.
        luh_burst(s_luh, "luh_rs", 1, 1, 1, 1, 3, 4);

        s = s_luh; s.wa_ex = 5'd0; s.rs_id = 5'd0;
        step(s, 1'b0, NONE, NONE, NONE, "luh_dest_zero");
        s = s_luh; s.us_rs = 1'b0; s.rt_id = 5'd3;
        step(s, 1'b0, NONE, NONE, NONE, "luh_rs_unused");
        s = s_luh; s.rw_ex = 1'b0;
        step(s, 1'b0, NONE, NONE, NONE, "luh_no_regwrite");
        s = s_luh; s.rs_id = 5'd3; s.rt_id = 5'd8;
        luh_burst(s, "luh_rt", 2, 3, 5, 2, 3, 8);

        // Taken branch masks a simultaneous load-use hazard.
        s = s_luh; s.br_ex = 1'b1; s.tk_ex = 1'b1;
        step(s, 1'b0, FLB, FLB, FLB, "brf_over_luh");
        step(idle, 1'b0, NONE, NONE, NONE, "brf_no_stall");
        s = idle; s.br_ex = 1'b1;
        step(s, 1'b0, NONE, NONE, NONE, "branch_not_taken");
        check_cnt(2, 3, 8, "brf_cnt");

        // IRQ held off by a branch in ID, then by kernel mode.
        s = idle; s.irq = 1'b1; s.brjmp = 1'b1;
        step(s, 1'b0, NONE, NONE, NONE, "irq_brjmp_a");
        s.irq = 1'b0;
        step(s, 1'b0, NONE, NONE, NONE, "irq_brjmp_b");
        step(idle, 1'b0, TAKE, TAKE, TAKE, "irq_take");
        step(idle, 1'b0, DRN, DRN, DRN, "irq_drain");
        step(idle, 1'b0, NONE, NONE, NONE, "irq_done");
        s = idle; s.irq = 1'b1; s.kern = 1'b1;
        step(s, 1'b0, NONE, NONE, NONE, "irq_kernel_a");
        s.irq = 1'b0;
        step(s, 1'b0, NONE, NONE, NONE, "irq_kernel_b");
        step(idle, 1'b0, TAKE, TAKE, TAKE, "irq_kernel_take");
        step(idle, 1'b0, DRN, DRN, DRN, "irq_kernel_drain");
        step(idle, 1'b0, NONE, NONE, NONE, "irq_kernel_done");

        // Load-use beats a pending IRQ; IRQ stays pending through STALL.
        s = idle; s.irq = 1'b1;
        step(s, 1'b0, NONE, NONE, NONE, "irq_luh_arm");
        step(s_luh, 1'b0, HOLD, HOLD, HOLD, "irq_luh_c0");
        step(idle, 1'b0, TAKE, HOLD, HOLD, "irq_luh_c1");
        step(idle, 1'b0, DRN, HOLD, HOLD, "irq_luh_c2");
        step(idle, 1'b0, NONE, TAKE, HOLD, "irq_luh_c3");
        step(idle, 1'b0, NONE, DRN, TAKE, "irq_luh_c4");
        step(idle, 1'b0, NONE, NONE, DRN, "irq_luh_c5");
        step(idle, 1'b0, NONE, NONE, NONE, "irq_luh_c6");
        check_cnt(3, 3, 12, "irq_luh_cnt");

        // Level IRQ during the take cycle: kept only if still high afterwards.
        s = idle; s.irq = 1'b1;
        step(s, 1'b0, NONE, NONE, NONE, "irq_lvl_arm");
        step(s, 1'b0, TAKE, TAKE, TAKE, "irq_lvl_take");
        step(s, 1'b0, DRN, DRN, DRN, "irq_lvl_drain");
        step(idle, 1'b0, TAKE, TAKE, TAKE, "irq_lvl_retake");
        step(idle, 1'b0, DRN, DRN, DRN, "irq_lvl_redrain");
        s = idle; s.irq = 1'b1;
        step(s, 1'b0, NONE, NONE, NONE, "irq_pls_arm");
        step(s, 1'b0, TAKE, TAKE, TAKE, "irq_pls_take");
        step(idle, 1'b0, DRN, DRN, DRN, "irq_pls_drain");
        step(idle, 1'b0, NONE, NONE, NONE, "irq_pls_lost");

        // Forwarding selects.
        step(fwd_stim(5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 5'd5), 1'b0,
             9'h008, 9'h008, 9'h008, "fwd_a_mem");
        step(fwd_stim(5'd5, 5'd7, 1'b1, 5'd0, 1'b1, 5'd5), 1'b0,
             9'h004, 9'h004, 9'h004, "fwd_a_wb");
        step(fwd_stim(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0), 1'b0,
             NONE, NONE, NONE, "fwd_zero_reg");
        step(fwd_stim(5'd9, 5'd9, 1'b0, 5'd9, 1'b1, 5'd9), 1'b0,
             9'h005, 9'h005, 9'h005, "fwd_mem_not_writing");
        step(fwd_stim(5'd3, 5'd12, 1'b1, 5'd12, 1'b1, 5'd3), 1'b0,
             9'h006, 9'h006, 9'h006, "fwd_split");
        s = fwd_stim(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 5'd0);
        s.br_ex = 1'b1; s.tk_ex = 1'b1;
        step(s, 1'b0, FLB | 9'h008, FLB | 9'h008, FLB | 9'h008, "fwd_during_brf");

        // Reset mid-stall with an IRQ pending.
        s = s_luh; s.irq = 1'b1;
        step(s, 1'b0, HOLD, HOLD, HOLD, "rst_stall_c0");
        step(idle, 1'b0, TAKE, HOLD, HOLD, "rst_stall_c1");
        check_state(HZ_STALL, "rst_stall_state");
        step(idle, 1'b1, NONE, NONE, NONE, "rst_stall_reset");
        step(idle, 1'b0, NONE, NONE, NONE, "rst_stall_release");
        check_state(HZ_RUN, "rst_stall_run");
        check_cnt(0, 0, 0, "rst_stall_cnt");
        step(idle, 1'b0, NONE, NONE, NONE, "rst_stall_no_irq_a");
        step(idle, 1'b0, NONE, NONE, NONE, "rst_stall_no_irq_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
